// File: rtl/apb_master_fsm_pkg.sv
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared APB requester state encoding and slave register map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    // Register map shared with the slave-side read logic
    localparam logic [1:0] REG_ERR_STATUS = 2'd0;
    localparam logic [1:0] REG_PAYLOAD_0  = 2'd1;
    localparam logic [1:0] REG_PAYLOAD_1  = 2'd2;
    localparam logic [1:0] REG_DATA_SIZE  = 2'd3;

endpackage : apb_pkg

`default_nettype wire

// File: rtl/apb_master_fsm_if.sv
// ============================================================================
//  Module      : apb_master_fsm_if
//  Description : Command/response port plus APB bus seen by the requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master_fsm_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel_x;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               psel_x, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               psel_x, penable, pwrite, paddr, pwdata
    );

endinterface : apb_master_fsm_if

`default_nettype wire

// File: rtl/apb_master_fsm_wait_timer.sv
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Saturating ACCESS wait-state counter with timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (clr) begin
            r_wait_cnt <= '0;
        end else if (inc && (r_wait_cnt != C_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign expired = (r_wait_cnt == C_LAST);

endmodule : apb_wait_timer

`default_nettype wire

// File: rtl/apb_master_fsm.sv
// ============================================================================
//  Module      : apb_master_fsm
//  Description : Single-outstanding APB requester with timeout abort.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_fsm
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             pclk,
    input  logic             preset_n,
    apb_master_fsm_if.master bus
);

    apb_state_t        r_state,     w_state;
    logic              r_psel,      w_psel;
    logic              r_penable,   w_penable;
    logic              r_pwrite,    w_pwrite;
    logic [ADDR_W-1:0] r_paddr,     w_paddr;
    logic [DATA_W-1:0] r_pwdata,    w_pwdata;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err,   w_rsp_err;
    logic              w_timer_clr;
    logic              w_timer_inc;
    logic              w_timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (pclk),
        .rst_n   (preset_n),
        .clr     (w_timer_clr),
        .inc     (w_timer_inc),
        .expired (w_timer_expired)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= APB_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end
    end

    // Response fields are single-cycle: they fall back to zero unless a transfer ends
    always_comb begin
        w_state     = r_state;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;

        case (r_state)
            APB_IDLE: begin
                if (bus.cmd_valid) begin
                    w_pwrite    = bus.cmd_write;
                    w_paddr     = bus.cmd_addr;
                    w_pwdata    = bus.cmd_wdata;
                    w_psel      = 1'b1;
                    w_timer_clr = 1'b1;
                    w_state     = APB_SETUP;
                end
            end
            APB_SETUP: begin
                w_penable = 1'b1;
                w_state   = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (bus.pready) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = r_pwrite ? '0 : bus.prdata;
                    w_psel      = 1'b0;
                    w_penable   = 1'b0;
                    w_state     = APB_IDLE;
                end else if (w_timer_expired) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_psel      = 1'b0;
                    w_penable   = 1'b0;
                    w_state     = APB_IDLE;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            default: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                w_state   = APB_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (r_state == APB_IDLE);
    assign bus.psel_x    = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule : apb_master_fsm

`default_nettype wire

// File: tb/tb_apb_master_fsm.sv
// ============================================================================
//  Module      : tb_apb_master_fsm
//  Description : Directed bench for apb_master_fsm with a small APB slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_fsm;
    import apb_pkg::*;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    always #5 pclk = ~pclk;

    apb_master_fsm_if #(.ADDR_W(2), .DATA_W(8)) bus ();

    apb_master_fsm #(
        .ADDR_W         (2),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus.master)
    );

    // Slave: inserts ws wait states per ACCESS, or never responds while stuck is set
    logic [7:0] regs [4] = '{8'h11, 8'hA5, 8'h5A, 8'h1F};
    int         acc_cnt = 0;
    int         ws = 0;
    bit         stuck = 1'b0;

    always_comb bus.pready = bus.penable && !stuck && (acc_cnt >= ws);
    assign bus.prdata = (bus.penable && bus.pready) ? regs[bus.paddr] : 8'h00;

    always @(posedge pclk) begin
        if (bus.psel_x && bus.penable) begin
            if (bus.pready) begin
                acc_cnt <= 0;
                if (bus.pwrite) regs[bus.paddr] <= bus.pwdata;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pclk);
    endtask

    task automatic send(input logic wr, input logic [1:0] addr, input logic [7:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    logic [7:0] exp_b2b [4] = '{8'h11, 8'hA5, 8'h3C, 8'h1F};

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 2'd0;
        bus.cmd_wdata = 8'h00;

        // Reset state
        cyc(); cyc();
        chk("rst_psel",    32'(bus.psel_x),    0);
        chk("rst_penable", 32'(bus.penable),   0);
        chk("rst_pwrite",  32'(bus.pwrite),    0);
        chk("rst_paddr",   32'(bus.paddr),     0);
        chk("rst_pwdata",  32'(bus.pwdata),    0);
        chk("rst_rsp_v",   32'(bus.rsp_valid), 0);
        chk("rst_rsp_d",   32'(bus.rsp_rdata), 0);
        chk("rst_rsp_e",   32'(bus.rsp_err),   0);
        preset_n = 1'b1;
        cyc();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);

        // Read, zero wait states
        send(1'b0, REG_PAYLOAD_0, 8'h00);
        cyc();
        bus.cmd_valid = 1'b0;
        chk("rd_setup_psel",  32'(bus.psel_x),    1);
        chk("rd_setup_pen",   32'(bus.penable),   0);
        chk("rd_setup_ready", 32'(bus.cmd_ready), 0);
        chk("rd_setup_addr",  32'(bus.paddr),     1);
        cyc();
        chk("rd_acc_psel", 32'(bus.psel_x),    1);
        chk("rd_acc_pen",  32'(bus.penable),   1);
        chk("rd_acc_rspv", 32'(bus.rsp_valid), 0);
        cyc();
        chk("rd_rsp_v",    32'(bus.rsp_valid), 1);
        chk("rd_rsp_d",    32'(bus.rsp_rdata), 'hA5);
        chk("rd_rsp_e",    32'(bus.rsp_err),   0);
        chk("rd_done_psel", 32'(bus.psel_x),   0);
        chk("rd_done_pen", 32'(bus.penable),   0);
        chk("rd_done_rdy", 32'(bus.cmd_ready), 1);
        cyc();
        chk("rd_pulse_end", 32'(bus.rsp_valid), 0);

        // Write; the command bus changes after acceptance and must not leak through
        send(1'b1, REG_PAYLOAD_1, 8'h3C);
        cyc();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 8'hFF;
        bus.cmd_addr  = 2'd0;
        chk("wr_setup_pwrite", 32'(bus.pwrite), 1);
        chk("wr_setup_pwdata", 32'(bus.pwdata), 'h3C);
        chk("wr_setup_paddr",  32'(bus.paddr),  2);
        cyc();
        chk("wr_acc_pwrite", 32'(bus.pwrite),  1);
        chk("wr_acc_pwdata", 32'(bus.pwdata),  'h3C);
        chk("wr_acc_pen",    32'(bus.penable), 1);
        cyc();
        chk("wr_rsp_v", 32'(bus.rsp_valid), 1);
        chk("wr_rsp_d", 32'(bus.rsp_rdata), 0);
        chk("wr_rsp_e", 32'(bus.rsp_err),   0);

        // Three wait states: ready arrives on the last ACCESS cycle before timeout
        ws = 3;
        send(1'b0, REG_DATA_SIZE, 8'h00);
        cyc();
        bus.cmd_valid = 1'b0;
        chk("ws_setup_pen", 32'(bus.penable), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ws_acc_pen",  32'(bus.penable),   1);
            chk("ws_acc_addr", 32'(bus.paddr),     3);
            chk("ws_acc_rspv", 32'(bus.rsp_valid), 0);
        end
        cyc();
        chk("ws_rsp_v",   32'(bus.rsp_valid), 1);
        chk("ws_rsp_d",   32'(bus.rsp_rdata), 'h1F);
        chk("ws_rsp_e",   32'(bus.rsp_err),   0);
        chk("ws_end_pen", 32'(bus.penable),   0);
        ws = 0;

        // Timeout with pready stuck low
        stuck = 1'b1;
        send(1'b0, REG_ERR_STATUS, 8'h00);
        cyc();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("to_acc_pen",  32'(bus.penable),   1);
            chk("to_acc_rspv", 32'(bus.rsp_valid), 0);
        end
        cyc();
        chk("to_psel",  32'(bus.psel_x),    0);
        chk("to_pen",   32'(bus.penable),   0);
        chk("to_rsp_v", 32'(bus.rsp_valid), 1);
        chk("to_rsp_e", 32'(bus.rsp_err),   1);
        chk("to_rsp_d", 32'(bus.rsp_rdata), 0);
        chk("to_ready", 32'(bus.cmd_ready), 1);
        stuck = 1'b0;
        cyc();
        chk("to_err_clr", 32'(bus.rsp_err), 0);

        // Back-to-back reads of all four registers with cmd_valid held high
        for (int c = 0; c <= 12; c++) begin
            if (c <= 9) send(1'b0, 2'(c / 3), 8'h00);
            else        bus.cmd_valid = 1'b0;
            chk("b2b_ready", 32'(bus.cmd_ready), (c % 3 == 0) ? 1 : 0);
            chk("b2b_rspv",  32'(bus.rsp_valid), (c >= 3 && c % 3 == 0) ? 1 : 0);
            if (c >= 3 && c % 3 == 0)
                chk("b2b_rspd", 32'(bus.rsp_rdata), 32'(exp_b2b[c / 3 - 1]));
            cyc();
        end

        // Reset in the middle of ACCESS
        ws = 5;
        send(1'b0, REG_PAYLOAD_0, 8'h00);
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        chk("mr_acc_pen", 32'(bus.penable), 1);
        #2 preset_n = 1'b0;
        #1;
        chk("mr_async_psel", 32'(bus.psel_x),    0);
        chk("mr_async_pen",  32'(bus.penable),   0);
        chk("mr_async_rspv", 32'(bus.rsp_valid), 0);
        cyc(); cyc();
        preset_n = 1'b1;
        ws = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mr_ready", 32'(bus.cmd_ready), 1);
            chk("mr_psel",  32'(bus.psel_x),    0);
            chk("mr_rspv",  32'(bus.rsp_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_master_fsm

`default_nettype wire
